// File: rtl/display_scan_capture.sv
// Captures a multiplexed 4-digit active-low 7-segment scan into per-digit
// raw patterns, decoded hex nibbles and decimal points.
module display_scan_capture #(
  parameter int SETTLE_CYCLES  = 64,
  parameter int TIMEOUT_CYCLES = 131072
) (
  input  logic        clock_50MHz,
  input  logic        reset,
  input  logic [3:0]  digits,
  input  logic [7:0]  segments,
  output logic [31:0] raw,
  output logic [15:0] value,
  output logic [3:0]  code_ok,
  output logic [3:0]  dp,
  output logic        frame_valid,
  output logic        scan_error,
  output logic        scan_timeout
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [SW-1:0] S_MAX  = SW'(SETTLE_CYCLES);
  localparam logic [SW-1:0] S_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [3:0]    dig_m;
  logic [3:0]    dig_s;
  logic [3:0]    dig_p;
  logic [7:0]    seg_m;
  logic [7:0]    seg_s;
  logic [7:0]    seg_p;
  logic [SW-1:0] stab_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [3:0]    mask;

  logic       sel_chg;
  logic       seg_chg;
  logic       legal;
  logic       blank;
  logic       illegal;
  logic [1:0] idx;
  logic [3:0] dec_val;
  logic       dec_ok;
  logic       cap;
  logic       tmo_hit;
  logic [3:0] mask_n;

  // Previous-cycle copies sit after the synchronizer for change detection
  always_ff @(posedge clock_50MHz) begin
    if (reset) begin
      dig_m <= 4'hF;
      dig_s <= 4'hF;
      dig_p <= 4'hF;
      seg_m <= 8'hFF;
      seg_s <= 8'hFF;
      seg_p <= 8'hFF;
    end else begin
      dig_m <= digits;
      dig_s <= dig_m;
      dig_p <= dig_s;
      seg_m <= segments;
      seg_s <= seg_m;
      seg_p <= seg_s;
    end
  end

  assign sel_chg = (dig_s != dig_p);
  assign seg_chg = (seg_s != seg_p);

  always_comb begin
    legal = 1'b0;
    blank = 1'b0;
    idx   = 2'd0;
    unique case (dig_s)
      4'b1110: begin legal = 1'b1; idx = 2'd0; end
      4'b1101: begin legal = 1'b1; idx = 2'd1; end
      4'b1011: begin legal = 1'b1; idx = 2'd2; end
      4'b0111: begin legal = 1'b1; idx = 2'd3; end
      4'b1111: blank = 1'b1;
      default: ;
    endcase
  end

  assign illegal = !legal && !blank;

  always_comb begin
    dec_val = 4'h0;
    dec_ok  = 1'b1;
    unique case (seg_s[6:0])
      7'b1000000: dec_val = 4'h0;
      7'b1111001: dec_val = 4'h1;
      7'b0100100: dec_val = 4'h2;
      7'b0110000: dec_val = 4'h3;
      7'b0011001: dec_val = 4'h4;
      7'b0010010: dec_val = 4'h5;
      7'b0000010: dec_val = 4'h6;
      7'b1111000: dec_val = 4'h7;
      7'b0000000: dec_val = 4'h8;
      7'b0010000: dec_val = 4'h9;
      7'b0001000: dec_val = 4'hA;
      7'b0000011: dec_val = 4'hB;
      7'b1000110: dec_val = 4'hC;
      7'b0100001: dec_val = 4'hD;
      7'b0000110: dec_val = 4'hE;
      7'b0001110: dec_val = 4'hF;
      default:    dec_ok  = 1'b0;
    endcase
  end

  // Capture fires only on the step into saturation, so once per stable period
  assign cap = legal && !sel_chg && !seg_chg && (stab_cnt == S_LAST);
  assign tmo_hit = !sel_chg && (tmo_cnt == T_LAST);

  always_comb begin
    mask_n = mask;
    if (mask == 4'hF)
      mask_n = 4'h0;
    if (tmo_hit && !cap)
      mask_n = 4'h0;
    if (cap)
      mask_n = mask_n | (4'b0001 << idx);
  end

  always_ff @(posedge clock_50MHz) begin
    if (reset) begin
      stab_cnt <= '0;
      tmo_cnt  <= '0;
      mask     <= 4'h0;
    end else begin
      if (sel_chg || seg_chg || illegal)
        stab_cnt <= '0;
      else if (stab_cnt != S_MAX)
        stab_cnt <= stab_cnt + 1'b1;
      if (sel_chg)
        tmo_cnt <= '0;
      else if (tmo_cnt != T_MAX)
        tmo_cnt <= tmo_cnt + 1'b1;
      mask <= mask_n;
    end
  end

  always_ff @(posedge clock_50MHz) begin
    if (reset) begin
      raw          <= 32'hFFFF_FFFF;
      value        <= 16'h0;
      code_ok      <= 4'h0;
      dp           <= 4'h0;
      frame_valid  <= 1'b0;
      scan_error   <= 1'b0;
      scan_timeout <= 1'b0;
    end else begin
      frame_valid <= (mask == 4'hF);
      scan_error  <= illegal && sel_chg;
      if (cap)
        scan_timeout <= 1'b0;
      else if (tmo_hit)
        scan_timeout <= 1'b1;
      if (cap) begin
        raw[{idx, 3'b000} +: 8]  <= seg_s;
        value[{idx, 2'b00} +: 4] <= dec_val;
        code_ok[idx]             <= dec_ok;
        dp[idx]                  <= ~seg_s[7];
      end
    end
  end

endmodule

// File: tb/tb_display_scan_capture.sv
// Directed table-driven bench for display_scan_capture.
// Each record holds inputs for a number of cycles, then checks outputs.
module tb_display_scan_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  digits;
  logic [7:0]  segments;
  logic [31:0] raw;
  logic [15:0] value;
  logic [3:0]  code_ok;
  logic [3:0]  dp;
  logic        frame_valid;
  logic        scan_error;
  logic        scan_timeout;

  int tests  = 0;
  int failed = 0;
  int fv_cnt = 0;
  int er_cnt = 0;

  display_scan_capture #(
    .SETTLE_CYCLES (64),
    .TIMEOUT_CYCLES(2000)
  ) dut (
    .clock_50MHz (clk),
    .reset       (reset),
    .digits      (digits),
    .segments    (segments),
    .raw         (raw),
    .value       (value),
    .code_ok     (code_ok),
    .dp          (dp),
    .frame_valid (frame_valid),
    .scan_error  (scan_error),
    .scan_timeout(scan_timeout)
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (frame_valid) fv_cnt++;
    if (scan_error)  er_cnt++;
  end

  typedef struct {
    logic        rst;
    logic [3:0]  dig;
    logic [7:0]  seg;
    int          hold;
    logic [31:0] raw;
    logic [15:0] val;
    logic [3:0]  ok;
    logic [3:0]  dp;
    int          fv;
    int          er;
    logic        to;
  } vec_t;

  localparam int NV = 25;
  vec_t vt[NV];

  function automatic vec_t mk(
    input logic rst, input logic [3:0] dig,
    input logic [7:0] seg, input int hold,
    input logic [31:0] r, input logic [15:0] v,
    input logic [3:0] ok, input logic [3:0] d,
    input int fv, input int er, input logic to);
    vec_t t;
    t.rst = rst; t.dig = dig; t.seg = seg;
    t.hold = hold; t.raw = r; t.val = v;
    t.ok = ok; t.dp = d; t.fv = fv;
    t.er = er; t.to = to;
    return t;
  endfunction

  task automatic chk(input string name, input int n,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s (step %0d): got %h, want %h",
               name, n, act, exp);
    end
  endtask

  initial begin
    int fv0;
    int er0;
    int n;

    // 0 / 1 / 8 / F glyphs, dp off (bit7 = 1)
    vt[0]  = mk(0, 4'b1110, 8'hC0, 100, 32'hFFFFFFC0, 16'h0000, 4'h1, 4'h0, 0, 0, 0);
    vt[1]  = mk(0, 4'b1101, 8'hF9, 100, 32'hFFFFF9C0, 16'h0010, 4'h3, 4'h0, 0, 0, 0);
    vt[2]  = mk(0, 4'b1011, 8'h80, 100, 32'hFF80F9C0, 16'h0810, 4'h7, 4'h0, 0, 0, 0);
    vt[3]  = mk(0, 4'b0111, 8'h8E, 100, 32'h8E80F9C0, 16'hF810, 4'hF, 4'h0, 1, 0, 0);
    vt[4]  = mk(0, 4'b1111, 8'hFF,  20, 32'h8E80F9C0, 16'hF810, 4'hF, 4'h0, 0, 0, 0);
    // glitch: digit 1 held only 40 cycles with a different glyph
    vt[5]  = mk(0, 4'b1110, 8'hC0, 100, 32'h8E80F9C0, 16'hF810, 4'hF, 4'h0, 0, 0, 0);
    vt[6]  = mk(0, 4'b1101, 8'hA4,  40, 32'h8E80F9C0, 16'hF810, 4'hF, 4'h0, 0, 0, 0);
    vt[7]  = mk(0, 4'b1011, 8'h80, 100, 32'h8E80F9C0, 16'hF810, 4'hF, 4'h0, 0, 0, 0);
    vt[8]  = mk(0, 4'b0111, 8'h8E, 100, 32'h8E80F9C0, 16'hF810, 4'hF, 4'h0, 0, 0, 0);
    vt[9]  = mk(0, 4'b1101, 8'hF9, 100, 32'h8E80F9C0, 16'hF810, 4'hF, 4'h0, 1, 0, 0);
    // illegal select, then blanking
    vt[10] = mk(0, 4'b1100, 8'hF9,  10, 32'h8E80F9C0, 16'hF810, 4'hF, 4'h0, 0, 1, 0);
    vt[11] = mk(0, 4'b1111, 8'hF9,  20, 32'h8E80F9C0, 16'hF810, 4'hF, 4'h0, 0, 0, 0);
    // all-off with dp lit on digit 2; '2' with dp on digit 0
    vt[12] = mk(0, 4'b1011, 8'h7F, 100, 32'h8E7FF9C0, 16'hF010, 4'hB, 4'h4, 0, 0, 0);
    vt[13] = mk(0, 4'b1110, 8'h24, 100, 32'h8E7FF924, 16'hF012, 4'hB, 4'h5, 0, 0, 0);
    vt[14] = mk(0, 4'b1101, 8'hF9, 100, 32'h8E7FF924, 16'hF012, 4'hB, 4'h5, 0, 0, 0);
    // reset after three captures; frame needs four fresh ones
    vt[15] = mk(1, 4'b0111, 8'h8E,  10, 32'hFFFFFFFF, 16'h0000, 4'h0, 4'h0, 0, 0, 0);
    vt[16] = mk(0, 4'b0111, 8'h8E, 100, 32'h8EFFFFFF, 16'hF000, 4'h8, 4'h0, 0, 0, 0);
    vt[17] = mk(0, 4'b1110, 8'hC0, 100, 32'h8EFFFFC0, 16'hF000, 4'h9, 4'h0, 0, 0, 0);
    vt[18] = mk(0, 4'b1101, 8'hF9, 100, 32'h8EFFF9C0, 16'hF010, 4'hB, 4'h0, 0, 0, 0);
    vt[19] = mk(0, 4'b1011, 8'h80, 100, 32'h8E80F9C0, 16'hF810, 4'hF, 4'h0, 1, 0, 0);
    // frozen scan -> timeout, data retained; fresh scan needed
    vt[20] = mk(0, 4'b1110, 8'hC0, 2100, 32'h8E80F9C0, 16'hF810, 4'hF, 4'h0, 0, 0, 1);
    vt[21] = mk(0, 4'b1101, 8'hF9, 100, 32'h8E80F9C0, 16'hF810, 4'hF, 4'h0, 0, 0, 0);
    vt[22] = mk(0, 4'b1011, 8'h80, 100, 32'h8E80F9C0, 16'hF810, 4'hF, 4'h0, 0, 0, 0);
    vt[23] = mk(0, 4'b0111, 8'h8E, 100, 32'h8E80F9C0, 16'hF810, 4'hF, 4'h0, 0, 0, 0);
    vt[24] = mk(0, 4'b1110, 8'hC0, 100, 32'h8E80F9C0, 16'hF810, 4'hF, 4'h0, 1, 0, 0);

    reset    = 1'b1;
    digits   = 4'hF;
    segments = 8'hFF;
    repeat (5) @(negedge clk);
    chk("rst_raw",   -1, raw, 32'hFFFFFFFF);
    chk("rst_value", -1, 32'(value), 32'h0);
    chk("rst_ok",    -1, 32'(code_ok), 32'h0);
    chk("rst_dp",    -1, 32'(dp), 32'h0);
    chk("rst_flags", -1,
        32'({frame_valid, scan_error, scan_timeout}), 32'h0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      reset    = vt[i].rst;
      digits   = vt[i].dig;
      segments = vt[i].seg;
      fv0 = fv_cnt;
      er0 = er_cnt;
      repeat (vt[i].hold) @(negedge clk);
      chk("raw",     i, raw, vt[i].raw);
      chk("value",   i, 32'(value), 32'(vt[i].val));
      chk("code_ok", i, 32'(code_ok), 32'(vt[i].ok));
      chk("dp",      i, 32'(dp), 32'(vt[i].dp));
      chk("frames",  i, 32'(fv_cnt - fv0), 32'(vt[i].fv));
      chk("errors",  i, 32'(er_cnt - er0), 32'(vt[i].er));
      chk("timeout", i, 32'(scan_timeout), 32'(vt[i].to));
    end

    // capture latency: sync stages plus settle window
    digits   = 4'b1101;
    segments = 8'hA4;
    n = 0;
    while (raw[15:8] !== 8'hA4 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("lat_raw", NV, 32'(raw[15:8]), 32'hA4);
    tests++;
    if (n < 64 || n > 72) begin
      failed++;
      $display("FAIL lat_cycles: got %0d, want 64..72", n);
    end
    chk("lat_value", NV, 32'(value), 32'hF820);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
